// File: rtl/fpu_mul_arbiter.sv
// Round-robin issue arbiter for the shared FPU multiplier: grants one of two requesters per cycle,
// tags each issued op with its owner across the fixed multiplier latency, and supports a drain handshake.
module fpu_mul_arbiter #(
  parameter int unsigned LAT = 3,
  parameter int unsigned W   = 32
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req0_valid_i,
  input  logic [W-1:0] req0_a_i,
  input  logic [W-1:0] req0_b_i,
  output logic         req0_ready_o,
  input  logic         req1_valid_i,
  input  logic [W-1:0] req1_a_i,
  input  logic [W-1:0] req1_b_i,
  output logic         req1_ready_o,
  output logic         mul_valid_o,
  output logic [W-1:0] mul_a_o,
  output logic [W-1:0] mul_b_o,
  input  logic [W-1:0] mul_result_i,
  output logic         rsp0_valid_o,
  output logic         rsp1_valid_o,
  output logic [W-1:0] rsp_data_o,
  input  logic         drain_req_i,
  output logic         drain_done_o
);

  localparam int unsigned CNT_MAX = LAT + 2;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             mv_q, mv_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             own_q, own_d;
  logic [LAT-1:0]   tag_v_q, tag_v_d;
  logic [LAT-1:0]   tag_o_q, tag_o_d;
  logic             rsp0_q, rsp0_d;
  logic             rsp1_q, rsp1_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic en_c, gnt0_c, gnt1_c, acc_c, rsp_any_c;

  // Grant: alternate on contention; reset held low blocks any acceptance
  always_comb begin
    en_c      = (state_q == S_RUN) && !drain_req_i && rst_ni;
    gnt0_c    = en_c && req0_valid_i && (!req1_valid_i || last_q);
    gnt1_c    = en_c && req1_valid_i && (!req0_valid_i || !last_q);
    acc_c     = gnt0_c || gnt1_c;
    rsp_any_c = rsp0_q || rsp1_q;
  end

  assign req0_ready_o = gnt0_c;
  assign req1_ready_o = gnt1_c;

  // Next-state: FSM, issue register, owner-tag pipeline, response and in-flight count
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    mv_d    = acc_c;
    a_d     = a_q;
    b_d     = b_q;
    own_d   = own_q;
    tag_v_d = tag_v_q;
    tag_o_d = tag_o_q;
    cnt_d   = cnt_q;

    if (gnt1_c) begin
      a_d    = req1_a_i;
      b_d    = req1_b_i;
      own_d  = 1'b1;
      last_d = 1'b1;
    end else if (gnt0_c) begin
      a_d    = req0_a_i;
      b_d    = req0_b_i;
      own_d  = 1'b0;
      last_d = 1'b0;
    end

    tag_v_d[0] = mv_q;
    tag_o_d[0] = own_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_o_d[i] = tag_o_q[i-1];
    end

    rsp0_d  = tag_v_q[LAT-1] && !tag_o_q[LAT-1];
    rsp1_d  = tag_v_q[LAT-1] &&  tag_o_q[LAT-1];
    rdata_d = tag_v_q[LAT-1] ? mul_result_i : rdata_q;

    case ({acc_c, rsp_any_c})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // DRAIN looks at the next count so drain_done rises right after the last response
    case (state_q)
      S_RUN:   if (drain_req_i) state_d = S_DRAIN;
      S_DRAIN: if (cnt_d == '0) state_d = S_DONE;
      S_DONE:  if (!drain_req_i) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_RUN;
      last_q  <= 1'b1;
      mv_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      own_q   <= 1'b0;
      tag_v_q <= '0;
      tag_o_q <= '0;
      rsp0_q  <= 1'b0;
      rsp1_q  <= 1'b0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      mv_q    <= mv_d;
      a_q     <= a_d;
      b_q     <= b_d;
      own_q   <= own_d;
      tag_v_q <= tag_v_d;
      tag_o_q <= tag_o_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mul_valid_o  = mv_q;
  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign rsp0_valid_o = rsp0_q;
  assign rsp1_valid_o = rsp1_q;
  assign rsp_data_o   = rdata_q;
  assign drain_done_o = done_q;

  // In-flight count is bounded by issue-to-response depth; leaving that range means lost tracking
  a_cnt_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(acc_c && !rsp_any_c && (cnt_q == CNT_W'(CNT_MAX))));
  a_cnt_unf: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_any_c && !acc_c && (cnt_q == '0)));

endmodule
